// File: rtl/arbiter_rr_8_pkg.sv
// arb_pkg: shared types and sizing for the 8-way round-robin arbiter.
package arb_pkg;
  localparam int N_REQ = 8;
  localparam int PTR_W = 3;
  localparam int WDOG_LIMIT = 16;
  typedef enum logic {IDLE, GRANT} state_t;
endpackage

// File: rtl/arbiter_rr_8_if.sv
// arbiter_rr_8_if: request/grant bundle; master = requesters, slave = arbiter.
interface arbiter_rr_8_if;
  import arb_pkg::*;
  logic [N_REQ-1:0] req;
  logic gnt_ack;
  logic [N_REQ-1:0] gnt;
  logic gnt_valid;
  logic timeout;
  modport master(output req, gnt_ack, input gnt, gnt_valid, timeout);
  modport slave(input req, gnt_ack, output gnt, gnt_valid, timeout);
endinterface

// File: rtl/arbiter_rr_8_rr_pick.sv
// rr_pick: first set request at or above ptr, wrapping, as one-hot and index.
module rr_pick
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] pick,
  output logic [PTR_W-1:0] idx,
  output logic             any
);
  always_comb begin
    idx = ptr;
    for (int i = N_REQ - 1; i >= 0; i--)
      if (req[ptr + PTR_W'(i)]) idx = ptr + PTR_W'(i);
    any = |req;
    pick = any ? N_REQ'(1) << idx : '0;
  end
endmodule

// File: rtl/arbiter_rr_8.sv
// arbiter_rr_8: 8-way round-robin arbiter holding each grant until acked.
// Optional grant watchdog enabled by defining ARB_WATCHDOG_EN.
module arbiter_rr_8
  import arb_pkg::*;
(
  input logic clk,
  input logic rst_n,
  arbiter_rr_8_if.slave bus
);
  state_t state, state_nx;
  logic [PTR_W-1:0] ptr, idx_r, pick_idx;
  logic [N_REQ-1:0] gnt_r, pick;
  logic any, rel;
  rr_pick u_pick (.req(bus.req), .ptr(ptr), .pick(pick), .idx(pick_idx), .any(any));
`ifdef ARB_WATCHDOG_EN
  logic [3:0] cnt;
  logic expire, timeout_r;
  // ack on the final cycle takes priority over expiry
  assign expire = state == GRANT && !bus.gnt_ack && cnt == 4'(WDOG_LIMIT - 1);
  assign rel = state == GRANT && (bus.gnt_ack || expire);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      timeout_r <= 1'b0;
    end else begin
      cnt <= state == GRANT ? cnt + 4'd1 : '0;
      timeout_r <= expire;
    end
  end
`else
  assign rel = state == GRANT && bus.gnt_ack;
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr <= '0;
      idx_r <= '0;
      gnt_r <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && any) begin
        gnt_r <= pick;
        idx_r <= pick_idx;
      end else if (rel) begin
        gnt_r <= '0;
        ptr <= idx_r + PTR_W'(1);
      end
    end
  end
  always_comb state_nx = rel ? IDLE : (state == IDLE && any) ? GRANT : state;
  always_comb begin
    bus.gnt = gnt_r;
    bus.gnt_valid = state == GRANT;
`ifdef ARB_WATCHDOG_EN
    bus.timeout = timeout_r;
`else
    bus.timeout = 1'b0;
`endif
  end
endmodule

// File: tb/tb_arbiter_rr_8.sv
// tb_arbiter_rr_8: directed and random checks of arbiter_rr_8 against an integer model.
module tb_arbiter_rr_8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n = 0;
  int fails = 0;
  int m_g = -1;
  int m_ptr = 0;
  int m_wd = 0;
  bit m_to = 1'b0;
`ifdef ARB_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif
  arbiter_rr_8_if bus ();
  arbiter_rr_8 dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic model(input logic [7:0] r, input bit a, input bit rn);
    if (!rn) begin
      m_g = -1; m_ptr = 0; m_wd = 0; m_to = 0;
    end else if (m_g < 0) begin
      m_to = 0;
      for (int k = 7; k >= 0; k--)
        if (r[(m_ptr + k) % 8]) m_g = (m_ptr + k) % 8;
      if (m_g >= 0) m_wd = 1;
    end else if (a) begin
      m_ptr = (m_g + 1) % 8; m_g = -1; m_to = 0;
    end else if (WD && m_wd == 16) begin
      m_ptr = (m_g + 1) % 8; m_g = -1; m_to = 1;
    end else begin
      m_wd++; m_to = 0;
    end
  endtask

  task automatic cyc(input logic [7:0] r, input bit a, input bit rn, input string tag);
    logic [7:0] eg;
    bus.req = r;
    bus.gnt_ack = a;
    rst_n = rn;
    @(posedge clk);
    model(r, a, rn);
    eg = m_g < 0 ? 8'h00 : 8'h01 << m_g;
    #1;
    n++;
    assert (bus.gnt === eg) else begin
      fails++;
      $error("FAIL %s gnt observed=%h expected=%h", tag, bus.gnt, eg);
    end
    n++;
    assert (bus.gnt_valid === (eg != 0)) else begin
      fails++;
      $error("FAIL %s gnt_valid observed=%b expected=%b", tag, bus.gnt_valid, eg != 0);
    end
    n++;
    assert (bus.timeout === m_to) else begin
      fails++;
      $error("FAIL %s timeout observed=%b expected=%b", tag, bus.timeout, m_to);
    end
  endtask

  initial begin
    bus.req = '0;
    bus.gnt_ack = 1'b0;
    repeat (3) cyc(8'h00, 1'b1, 1'b0, "reset");
    repeat (10) cyc(8'h00, 1'b0, 1'b1, "idle");
    repeat (9) cyc(8'h24, m_g >= 0, 1'b1, "req24");
    cyc(8'h00, 1'b0, 1'b0, "rst2");
    repeat (20) cyc(8'hFF, m_g >= 0, 1'b1, "walk");
    cyc(8'h00, 1'b0, 1'b0, "rst3");
    cyc(8'h08, 1'b0, 1'b1, "g08");
    repeat (5) cyc(8'h00, 1'b0, 1'b1, "hold08");
    cyc(8'h00, 1'b1, 1'b1, "ack08");
    cyc(8'h00, 1'b0, 1'b1, "idle08");
    cyc(8'h00, 1'b0, 1'b0, "rst4");
    repeat (20) cyc(8'h81, 1'b0, 1'b1, "wdog");
    cyc(8'h00, 1'b1, 1'b1, "wdog_ack");
    cyc(8'h00, 1'b0, 1'b1, "wdog_idle");
    cyc(8'h81, 1'b0, 1'b1, "ack16_g");
    repeat (17) cyc(8'h81, m_g >= 0 && m_wd == 16, 1'b1, "ack16");
    cyc(8'h00, 1'b1, 1'b1, "ack16_rel");
    cyc(8'h00, 1'b0, 1'b0, "rst5");
    cyc(8'h10, 1'b0, 1'b1, "g10");
    cyc(8'h10, 1'b0, 1'b1, "hold10");
    cyc(8'h10, 1'b0, 1'b0, "rst_mid");
    cyc(8'h11, 1'b0, 1'b1, "g11");
    cyc(8'h11, 1'b1, 1'b1, "ack11");
    for (int i = 0; i < 400; i++)
      cyc(8'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 63) != 0, "rand");
    $display("End of test - %0d assertions evaluated, %0d failures", n, fails);
    $finish;
  end
endmodule
